// File: rtl/fft_freq_analyzer.sv
// Dominant-bin detector for 16-bin FFT frames: scans one bin per cycle and
// reports the index of the largest |X[k]|^2, with a one-deep pending buffer.
module fft_freq_analyzer #(
    parameter bit SKIP_DC = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fft_valid,
    input  logic [31:0] fft_d0,
    input  logic [31:0] fft_d1,
    input  logic [31:0] fft_d2,
    input  logic [31:0] fft_d3,
    input  logic [31:0] fft_d4,
    input  logic [31:0] fft_d5,
    input  logic [31:0] fft_d6,
    input  logic [31:0] fft_d7,
    input  logic [31:0] fft_d8,
    input  logic [31:0] fft_d9,
    input  logic [31:0] fft_d10,
    input  logic [31:0] fft_d11,
    input  logic [31:0] fft_d12,
    input  logic [31:0] fft_d13,
    input  logic [31:0] fft_d14,
    input  logic [31:0] fft_d15,
    output logic        done,
    output logic [3:0]  freq,
    output logic        busy,
    output logic        ovf
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    logic [31:0] fft_in_s [16];
    logic [31:0] work_q [16];
    logic [31:0] work_d [16];
    logic [31:0] pend_q [16];
    logic [31:0] pend_d [16];

    logic [0:0]  state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] best_mag_q, best_mag_d;
    logic [3:0]  best_idx_q, best_idx_d;
    logic        have_q, have_d;
    logic        pend_vld_q, pend_vld_d;
    logic        ovf_q, ovf_d;
    logic        done_q, done_d;
    logic [3:0]  freq_q, freq_d;
    logic        busy_q, busy_d;

    logic [31:0]        cur_s;
    logic signed [31:0] re_s, im_s;
    logic signed [31:0] re_sq_s, im_sq_s;
    logic [31:0]        mag_s;
    logic               elig_s;
    logic               take_s;
    logic [3:0]         win_idx_s;

    assign fft_in_s[0]  = fft_d0;
    assign fft_in_s[1]  = fft_d1;
    assign fft_in_s[2]  = fft_d2;
    assign fft_in_s[3]  = fft_d3;
    assign fft_in_s[4]  = fft_d4;
    assign fft_in_s[5]  = fft_d5;
    assign fft_in_s[6]  = fft_d6;
    assign fft_in_s[7]  = fft_d7;
    assign fft_in_s[8]  = fft_d8;
    assign fft_in_s[9]  = fft_d9;
    assign fft_in_s[10] = fft_d10;
    assign fft_in_s[11] = fft_d11;
    assign fft_in_s[12] = fft_d12;
    assign fft_in_s[13] = fft_d13;
    assign fft_in_s[14] = fft_d14;
    assign fft_in_s[15] = fft_d15;

    // Squared magnitude of the bin under the scan pointer; (-2^15)^2 = 2^30 still fits signed 32.
    always_comb begin
        cur_s     = work_q[idx_q];
        re_s      = {{16{cur_s[31]}}, cur_s[31:16]};
        im_s      = {{16{cur_s[15]}}, cur_s[15:0]};
        re_sq_s   = re_s * re_s;
        im_sq_s   = im_s * im_s;
        mag_s     = $unsigned(re_sq_s) + $unsigned(im_sq_s);
        elig_s    = !(SKIP_DC && (idx_q == 4'd0));
        take_s    = elig_s && (!have_q || (mag_s > best_mag_q));
        win_idx_s = take_s ? idx_q : best_idx_q;
    end

    // Next-state logic: frame load, scan step, end-of-scan reload and pending capture.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        best_mag_d = best_mag_q;
        best_idx_d = best_idx_q;
        have_d     = have_q;
        pend_vld_d = pend_vld_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        freq_d     = freq_q;
        for (int i = 0; i < 16; i++) begin
            work_d[i] = work_q[i];
            pend_d[i] = pend_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (fft_valid) begin
                    for (int i = 0; i < 16; i++) work_d[i] = fft_in_s[i];
                    idx_d   = 4'd0;
                    have_d  = 1'b0;
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (take_s) begin
                    best_mag_d = mag_s;
                    best_idx_d = idx_q;
                    have_d     = 1'b1;
                end else begin
                    have_d     = have_q;
                end
                if (idx_q == 4'd15) begin
                    done_d = 1'b1;
                    freq_d = win_idx_s;
                    idx_d  = 4'd0;
                    have_d = 1'b0;
                    // A frame arriving on the last bin bypasses the pending buffer.
                    if (fft_valid) begin
                        for (int i = 0; i < 16; i++) work_d[i] = fft_in_s[i];
                        state_d = ST_SCAN;
                    end else if (pend_vld_q) begin
                        for (int i = 0; i < 16; i++) work_d[i] = pend_q[i];
                        pend_vld_d = 1'b0;
                        state_d    = ST_SCAN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    idx_d = idx_q + 4'd1;
                    if (fft_valid) begin
                        for (int i = 0; i < 16; i++) pend_d[i] = fft_in_s[i];
                        pend_vld_d = 1'b1;
                        if (pend_vld_q) begin
                            ovf_d = 1'b1;
                        end else begin
                            ovf_d = ovf_q;
                        end
                    end else begin
                        pend_vld_d = pend_vld_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_SCAN);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= 4'd0;
            best_mag_q <= 32'd0;
            best_idx_q <= 4'd0;
            have_q     <= 1'b0;
            pend_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            freq_q     <= 4'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            best_mag_q <= best_mag_d;
            best_idx_q <= best_idx_d;
            have_q     <= have_d;
            pend_vld_q <= pend_vld_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            freq_q     <= freq_d;
            busy_q     <= busy_d;
        end
    end

    // Frame buffers; contents are don't-care while their valid state is clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                work_q[i] <= 32'd0;
                pend_q[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                work_q[i] <= work_d[i];
                pend_q[i] <= pend_d[i];
            end
        end
    end

    assign done = done_q;
    assign freq = freq_q;
    assign busy = busy_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_fft_freq_analyzer.sv
// Directed bench for fft_freq_analyzer: two instances (SKIP_DC = 1 and 0) share stimulus.
module tb_fft_freq_analyzer;

    logic        clk;
    logic        rst;
    logic        fft_valid;
    logic [31:0] tb_d [16];

    logic        done1, busy1, ovf1;
    logic [3:0]  freq1;
    logic        done0, busy0, ovf0;
    logic [3:0]  freq0;

    int n_tests;
    int n_fail;

    logic [31:0] fbank [4][16];
    int          sched     [64];
    bit          exp_done  [64];
    bit          exp_busy  [64];
    bit          exp_ovf   [64];
    logic [3:0]  exp_freq  [64];
    logic [3:0]  exp_freq0 [64];
    int          rst_at;
    int          rel_at;

    fft_freq_analyzer #(.SKIP_DC(1'b1)) dut (
        .clk(clk), .rst(rst), .fft_valid(fft_valid),
        .fft_d0(tb_d[0]), .fft_d1(tb_d[1]), .fft_d2(tb_d[2]), .fft_d3(tb_d[3]),
        .fft_d4(tb_d[4]), .fft_d5(tb_d[5]), .fft_d6(tb_d[6]), .fft_d7(tb_d[7]),
        .fft_d8(tb_d[8]), .fft_d9(tb_d[9]), .fft_d10(tb_d[10]), .fft_d11(tb_d[11]),
        .fft_d12(tb_d[12]), .fft_d13(tb_d[13]), .fft_d14(tb_d[14]), .fft_d15(tb_d[15]),
        .done(done1), .freq(freq1), .busy(busy1), .ovf(ovf1)
    );

    fft_freq_analyzer #(.SKIP_DC(1'b0)) dut0 (
        .clk(clk), .rst(rst), .fft_valid(fft_valid),
        .fft_d0(tb_d[0]), .fft_d1(tb_d[1]), .fft_d2(tb_d[2]), .fft_d3(tb_d[3]),
        .fft_d4(tb_d[4]), .fft_d5(tb_d[5]), .fft_d6(tb_d[6]), .fft_d7(tb_d[7]),
        .fft_d8(tb_d[8]), .fft_d9(tb_d[9]), .fft_d10(tb_d[10]), .fft_d11(tb_d[11]),
        .fft_d12(tb_d[12]), .fft_d13(tb_d[13]), .fft_d14(tb_d[14]), .fft_d15(tb_d[15]),
        .done(done0), .freq(freq0), .busy(busy0), .ovf(ovf0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic mk_peak(input int slot, input int bin);
        for (int i = 0; i < 16; i++) fbank[slot][i] = 32'h0000_0000;
        fbank[slot][bin] = 32'h0100_0000;
    endtask

    task automatic clear_sched(input bit ovf_now);
        for (int c = 0; c < 64; c++) begin
            sched[c]     = -1;
            exp_done[c]  = 1'b0;
            exp_busy[c]  = 1'b0;
            exp_ovf[c]   = ovf_now;
            exp_freq[c]  = 4'd0;
            exp_freq0[c] = 4'd0;
        end
        rst_at = -1;
        rel_at = -1;
    endtask

    task automatic expect_done(input int c, input logic [3:0] f1, input logic [3:0] f0);
        exp_done[c]  = 1'b1;
        exp_freq[c]  = f1;
        exp_freq0[c] = f0;
    endtask

    task automatic busy_span(input int a, input int b);
        for (int c = a; c <= b; c++) exp_busy[c] = 1'b1;
    endtask

    // Cycle c: drive #1 after its opening edge, check outputs #2 after it.
    task automatic run_cycles(input string name, input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            if (sched[c] >= 0) begin
                fft_valid = 1'b1;
                for (int i = 0; i < 16; i++) tb_d[i] = fbank[sched[c]][i];
            end else begin
                fft_valid = 1'b0;
                for (int i = 0; i < 16; i++) tb_d[i] = 32'h0000_0000;
            end
            if (c == rst_at) rst = 1'b0;
            if (c == rel_at) rst = 1'b1;
            #1;
            check_eq($sformatf("%s done c%0d", name, c), {31'd0, done1}, {31'd0, exp_done[c]});
            check_eq($sformatf("%s done0 c%0d", name, c), {31'd0, done0}, {31'd0, exp_done[c]});
            check_eq($sformatf("%s busy c%0d", name, c), {31'd0, busy1}, {31'd0, exp_busy[c]});
            check_eq($sformatf("%s ovf c%0d", name, c), {31'd0, ovf1}, {31'd0, exp_ovf[c]});
            if (exp_done[c]) begin
                check_eq($sformatf("%s freq c%0d", name, c), {28'd0, freq1}, {28'd0, exp_freq[c]});
                check_eq($sformatf("%s freq0 c%0d", name, c), {28'd0, freq0}, {28'd0, exp_freq0[c]});
            end
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b0;
        fft_valid = 1'b0;
        for (int i = 0; i < 16; i++) tb_d[i] = 32'h0000_0000;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst done", {31'd0, done1}, 32'd0);
        check_eq("rst freq", {28'd0, freq1}, 32'd0);
        check_eq("rst busy", {31'd0, busy1}, 32'd0);
        check_eq("rst ovf", {31'd0, ovf1}, 32'd0);
        rst = 1'b1;

        // Single peak at bin 3.
        clear_sched(1'b0);
        mk_peak(0, 3);
        sched[0] = 0;
        expect_done(17, 4'd3, 4'd3);
        busy_span(1, 16);
        run_cycles("peak3", 20);

        // Real signal: bins 1 and 15 tie, strong DC only wins when not skipped.
        clear_sched(1'b0);
        for (int i = 0; i < 16; i++) fbank[0][i] = 32'h0000_0000;
        fbank[0][0]  = 32'h7FFF_0000;
        fbank[0][1]  = 32'h0200_FE00;
        fbank[0][15] = 32'h0200_FE00;
        sched[0] = 0;
        expect_done(17, 4'd1, 4'd0);
        busy_span(1, 16);
        run_cycles("tie", 20);

        // Extreme values: 2^31 beats 2*(2^15-1)^2.
        clear_sched(1'b0);
        for (int i = 0; i < 16; i++) fbank[0][i] = 32'h0000_0000;
        fbank[0][5] = 32'h8000_8000;
        fbank[0][6] = 32'h7FFF_7FFF;
        sched[0] = 0;
        expect_done(17, 4'd5, 4'd5);
        busy_span(1, 16);
        run_cycles("extreme", 20);

        // Back-to-back via direct reload.
        clear_sched(1'b0);
        mk_peak(0, 2);
        mk_peak(1, 7);
        mk_peak(2, 14);
        sched[0] = 0; sched[16] = 1; sched[32] = 2;
        expect_done(17, 4'd2, 4'd2);
        expect_done(33, 4'd7, 4'd7);
        expect_done(49, 4'd14, 4'd14);
        busy_span(1, 48);
        run_cycles("b2b", 52);

        // Pending overwrite: frame at 8 replaces frame at 4.
        clear_sched(1'b0);
        mk_peak(0, 4);
        mk_peak(1, 9);
        mk_peak(2, 11);
        sched[0] = 0; sched[4] = 1; sched[8] = 2;
        expect_done(17, 4'd4, 4'd4);
        expect_done(33, 4'd11, 4'd11);
        busy_span(1, 32);
        for (int c = 9; c < 64; c++) exp_ovf[c] = 1'b1;
        run_cycles("ovw", 36);

        // Reset mid-scan with a pending frame, then a fresh frame.
        clear_sched(1'b1);
        mk_peak(0, 2);
        mk_peak(1, 9);
        mk_peak(2, 6);
        sched[0] = 0; sched[3] = 1; sched[26] = 2;
        rst_at = 8;
        rel_at = 10;
        for (int c = 8; c < 64; c++) exp_ovf[c] = 1'b0;
        busy_span(1, 7);
        busy_span(27, 42);
        expect_done(43, 4'd6, 4'd6);
        run_cycles("rstmid", 46);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_freq_analyzer.md
# fft_freq_analyzer

Consumes the 16-bin spectrum frames produced by the FFT stage of the FAS datapath (fft_valid plus fft_d0..fft_d15) and reports the dominant frequency bin. For each frame it computes |X[k]|² = re² + im² one bin per cycle with a single squaring datapath and tracks the maximum. It then pulses done with freq set to the winning bin index. It sits on the receive side of the FFT output interface and drives the done/freq pair of the top level.

## Interface
- SKIP_DC, default 1: when 1, bin 0 is excluded from the search; when 0, bin 0 competes normally.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- fft_valid  input  1  one-cycle strobe; fft_d0..fft_d15 are valid in the same cycle.
- fft_d0 .. fft_d15  input  32 each  bin k: [31:16] signed real, [15:0] signed imaginary (8.8 fixed point).
- done  output  1  one-cycle pulse; freq is valid in that cycle.
- freq  output  4  index of the winning bin; held until the next done.
- busy  output  1  high while a frame is being scanned.
- ovf  output  1  sticky; set when a pending frame is overwritten; cleared only by reset.

## Operation
- Storage: a work buffer (16×32) and a pending buffer (16×32) with a pending-valid flag.
- IDLE state:
  - fft_valid loads the work buffer.
  - Scan index n is set to 0; go to SCAN.
- SCAN state: one bin per cycle, n = 0..15.
  - mag = re*re + im*im, computed as a 32-bit unsigned sum. Each product is at most 2^30, so the sum is at most 2^31 and cannot overflow.
  - If bin n is eligible and mag > best_mag (strictly greater), or it is the first eligible bin, update best_mag and best_idx to n.
  - Ties keep the lower index. For a real input where bins 1 and 15 are equal, freq = 1.
  - With SKIP_DC = 1, bin 0 is never eligible and the first eligible bin is 1.
- End of scan, on the cycle with n = 15:
  - Register done = 1 and freq = best_idx for the following cycle.
  - Choose the next state, in this priority order:
    1. If fft_valid is high in that same cycle, load the work buffer directly from the inputs and restart SCAN with n = 0.
    2. Otherwise, if pending-valid is set, copy the pending buffer to the work buffer, clear pending-valid, and restart SCAN.
    3. Otherwise, go to IDLE.
- fft_valid during SCAN on cycles with n = 0..14:
  - Capture the inputs into the pending buffer and set pending-valid.
  - If pending-valid was already set, overwrite the pending buffer (newest frame wins) and set ovf.
- Reset (asynchronous, at any time including mid-scan):
  - State returns to IDLE.
  - The partial result and any pending frame are discarded.
  - done, freq, busy and ovf all go to 0.
  - No done is produced for the interrupted frame.

## Timing
- Reset values: done = 0, freq = 4'd0, busy = 0, ovf = 0.
- A frame accepted on the rising edge at the end of cycle T is scanned in cycles T+1..T+16; busy = 1 throughout those cycles.
- done = 1 in cycle T+17 only. freq changes in cycle T+17 and holds until the next done.
- Latency from fft_valid to done is 17 cycles.
- Sustained throughput is one frame every 16 cycles with no pending use. A frame arriving at T+16 hits the direct-reload path, busy stays 1, and the next done is at T+33.
- A frame taken from the pending buffer starts its scan in the cycle after the previous scan's last bin (T+17).
- busy falls to 0 in the cycle after the last bin only if nothing is reloaded.
- There is no back-pressure on fft_valid; data loss is signalled only through ovf.

## Test plan
- Frame with bin 3 = {0x0100, 0x0000} and all other bins 0, fft_valid at cycle T → done = 1 at T+17 only, freq = 3, busy = 1 during T+1..T+16.
- Real-signal frame with bins 1 and 15 both = {0x0200, 0xFE00}, bin 0 = {0x7FFF, 0}, SKIP_DC = 1 → freq = 1. Repeat with SKIP_DC = 0 → freq = 0.
- Extreme value: bin 5 = {0x8000, 0x8000} (mag = 2^31), bin 6 = {0x7FFF, 0x7FFF} → freq = 5 with no overflow.
- Back-to-back frames at T, T+16, T+32 with peaks at bins 2, 7, 14 → done at T+17, T+33, T+49 with freq = 2, 7, 14; busy never drops; ovf = 0.
- Frames at T, T+4 and T+8 (the frame at T+8 overwrites the one at T+4) → done at T+17 (frame 1) and T+33 (frame 3); ovf = 1 from T+9 until reset.
- rst asserted low at T+8 of a scan with a pending frame → outputs 0 immediately; no done appears. A new frame after release gives normal 17-cycle latency.
